// File: rtl/sdu_pkg.sv
// rtl/sdu_pkg.sv - shared types and constants for the SDU receive front end
package sdu_pkg;

  localparam int DEF_OS         = 16;
  localparam int DEF_FIFO_DEPTH = 4;

  // Bit-phase taps for the 3-sample vote; the last tap is where the bit is decided.
  localparam int TAP_A = 7;
  localparam int TAP_B = 8;
  localparam int TAP_C = 9;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/sdu_rx_frontend_if.sv
// rtl/sdu_rx_frontend_if.sv - serial line in, byte stream out with vld/rdy handshake
interface sdu_rx_frontend_if;

  logic       rxd;
  logic [7:0] d_rx;
  logic       vld_rx;
  logic       rdy_rx;
  logic       frm_err;
  logic       ovf;

  modport master (
    input  rxd,
    input  rdy_rx,
    output d_rx,
    output vld_rx,
    output frm_err,
    output ovf
  );

  modport slave (
    output rxd,
    output rdy_rx,
    input  d_rx,
    input  vld_rx,
    input  frm_err,
    input  ovf
  );

endinterface

// File: rtl/sdu_byte_fifo.sv
// rtl/sdu_byte_fifo.sv - first-word fall-through byte buffer with drop-on-full overflow pulse
module sdu_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       i_push,
  input  logic [7:0] i_push_data,
  output logic       o_ovf,
  output logic       o_vld,
  output logic [7:0] o_data,
  input  logic       i_rdy
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CNW = $clog2(DEPTH + 1);
  localparam logic [CNW-1:0] C_FULL = CNW'(DEPTH);

  logic [7:0]     r_mem [DEPTH];
  logic [AW-1:0]  r_wr;
  logic [AW-1:0]  r_rd;
  logic [CNW-1:0] r_count;
  logic           r_ovf;

  logic w_empty;
  logic w_pop;
  logic w_push_ok;

  assign w_empty   = (r_count == '0);
  assign w_pop     = !w_empty && i_rdy;
  // A pop in the same cycle frees the slot, so a full buffer still accepts the push.
  assign w_push_ok = i_push && ((r_count != C_FULL) || w_pop);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_ovf <= i_push && !w_push_ok;
      if (w_push_ok) r_wr <= r_wr + 1'b1;
      if (w_pop)     r_rd <= r_rd + 1'b1;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr] <= i_push_data;
  end

  assign o_vld  = !w_empty;
  assign o_data = w_empty ? 8'h00 : r_mem[r_rd];
  assign o_ovf  = r_ovf;

endmodule

// File: rtl/sdu_rx_frontend.sv
// rtl/sdu_rx_frontend.sv - 8N1 oversampling UART receiver feeding a small byte FIFO
module sdu_rx_frontend
  import sdu_pkg::*;
#(
  parameter int OS         = DEF_OS,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rstn,
  sdu_rx_frontend_if.master rx
);

  localparam int CW = $clog2(OS);
  localparam logic [CW-1:0] C_LAST = CW'(OS - 1);
  localparam logic [CW-1:0] C_A    = CW'(TAP_A);
  localparam logic [CW-1:0] C_B    = CW'(TAP_B);
  localparam logic [CW-1:0] C_C    = CW'(TAP_C);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic          r_sync1;
  logic          r_sync2;
  logic          r_s_a;
  logic          r_s_b;
  logic [7:0]    r_shift;
  logic          r_frm_err;

  logic          w_maj;
  logic          w_decide;
  logic          w_last;
  logic [CW-1:0] w_cnt_next;
  logic          w_push;

  assign w_maj      = maj3(r_s_a, r_s_b, r_sync2);
  assign w_decide   = (r_cnt == C_C);
  assign w_last     = (r_cnt == C_LAST);
  assign w_cnt_next = w_last ? '0 : r_cnt + 1'b1;
  // Push straight from the stop decision so the byte is visible the very next cycle.
  assign w_push     = (r_state == STOP) && w_decide && w_maj;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_s_a     <= 1'b1;
      r_s_b     <= 1'b1;
      r_shift   <= '0;
      r_frm_err <= 1'b0;
    end else begin
      r_sync1   <= rx.rxd;
      r_sync2   <= r_sync1;
      r_frm_err <= 1'b0;
      if (r_cnt == C_A) r_s_a <= r_sync2;
      if (r_cnt == C_B) r_s_b <= r_sync2;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (!r_sync2) r_state <= START;
        end
        START: begin
          r_cnt <= w_cnt_next;
          if (w_decide && w_maj) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (w_last) begin
            r_state <= DATA;
            r_bit   <= '0;
          end
        end
        DATA: begin
          r_cnt <= w_cnt_next;
          if (w_decide) r_shift <= {w_maj, r_shift[7:1]};
          if (w_last) begin
            if (r_bit == 3'd7) r_state <= STOP;
            else               r_bit   <= r_bit + 1'b1;
          end
        end
        STOP: begin
          r_cnt <= w_cnt_next;
          if (w_decide) begin
            r_cnt <= '0;
            if (w_maj) begin
              r_state <= IDLE;
            end else begin
              r_frm_err <= 1'b1;
              r_state   <= WAIT_IDLE;
            end
          end
        end
        WAIT_IDLE: begin
          r_cnt <= '0;
          if (r_sync2) r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  sdu_byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rstn       (rstn),
    .i_push     (w_push),
    .i_push_data(r_shift),
    .o_ovf      (rx.ovf),
    .o_vld      (rx.vld_rx),
    .o_data     (rx.d_rx),
    .i_rdy      (rx.rdy_rx)
  );

  assign rx.frm_err = r_frm_err;

endmodule

// File: tb/tb_sdu_rx_frontend.sv
// tb/tb_sdu_rx_frontend.sv - directed and randomized frames checked against a byte-level model
module tb_sdu_rx_frontend;
  import sdu_pkg::*;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  sdu_rx_frontend_if bus ();

  sdu_rx_frontend #(
    .OS        (16),
    .FIFO_DEPTH(4)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .rx  (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] mf_q[$];
  int got_frm = 0, exp_frm = 0;
  int got_ovf = 0, exp_ovf = 0;

  int spike_i = -1;
  int rst_i   = -1;
  int rdy_i   = -1;
  bit lat_chk = 1'b0;

  always @(negedge clk) begin
    if (rstn) begin
      if (bus.vld_rx && bus.rdy_rx) got_q.push_back(bus.d_rx);
      if (bus.frm_err) got_frm++;
      if (bus.ovf)     got_ovf++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_q(input string tag);
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0)
      chk({tag, "_byte"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    got_q.delete();
    exp_q.delete();
  endtask

  // Drives one 10-bit frame at 16 clocks per bit; the line is sampled by the DUT two flops later.
  task automatic send(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 160; i++) begin
      bus.rxd = (i == spike_i) ? ~fr[i/16] : fr[i/16];
      if (rdy_i >= 0 && i == rdy_i)     bus.rdy_rx = 1'b1;
      if (rdy_i >= 0 && i == rdy_i + 1) bus.rdy_rx = 1'b0;
      if (rst_i >= 0 && i == rst_i)     rstn = 1'b0;
      if (rst_i >= 0 && i == rst_i + 3) rstn = 1'b1;
      @(posedge clk);
      #1;
      if (lat_chk && i == 155) chk("vld_before_T155", 32'(bus.vld_rx), 32'd0);
      if (lat_chk && i == 156) begin
        chk("vld_at_T155", 32'(bus.vld_rx), 32'd1);
        chk("d_rx_at_T155", 32'(bus.d_rx), 32'(b));
      end
      if (lat_chk && i == 157) chk("vld_after_pop", 32'(bus.vld_rx), 32'd0);
      if (rst_i >= 0 && i == rst_i) begin
        chk("rst_mid_vld", 32'(bus.vld_rx), 32'd0);
        chk("rst_mid_d_rx", 32'(bus.d_rx), 32'd0);
        chk("rst_mid_state", 32'(dut.r_state), 32'(IDLE));
      end
    end
  endtask

  task automatic model_frame(input logic [7:0] b, input bit ready);
    if (ready)                 exp_q.push_back(b);
    else if (mf_q.size() < 4)  mf_q.push_back(b);
    else                       exp_ovf++;
  endtask

  initial begin
    logic [7:0] rb;
    bus.rxd    = 1'b1;
    bus.rdy_rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_vld", 32'(bus.vld_rx), 32'd0);
    chk("reset_d_rx", 32'(bus.d_rx), 32'd0);
    chk("reset_frm_err", 32'(bus.frm_err), 32'd0);
    chk("reset_ovf", 32'(bus.ovf), 32'd0);
    chk("reset_state", 32'(dut.r_state), 32'(IDLE));
    rstn = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    lat_chk = 1'b1;
    send(8'hA5, 1'b1);
    lat_chk = 1'b0;
    model_frame(8'hA5, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    check_q("a5");

    bus.rdy_rx = 1'b0;
    send(8'h3C, 1'b1); model_frame(8'h3C, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      send(8'(k), 1'b1);
      model_frame(8'(k), 1'b0);
    end
    repeat (4) @(posedge clk);
    #1;
    chk("full_vld", 32'(bus.vld_rx), 32'd1);
    chk("full_head", 32'(bus.d_rx), 32'h3C);
    chk("ovf_count", 32'(got_ovf), 32'(exp_ovf));

    rdy_i = 156;
    send(8'h06, 1'b1);
    rdy_i = -1;
    exp_q.push_back(mf_q.pop_front());
    mf_q.push_back(8'h06);
    chk("full_pushpop_ovf", 32'(got_ovf), 32'(exp_ovf));
    chk("full_pushpop_head", 32'(bus.d_rx), 32'h01);
    bus.rdy_rx = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    while (mf_q.size() > 0) exp_q.push_back(mf_q.pop_front());
    check_q("overflow");

    bus.rxd = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    bus.rxd = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("glitch_vld", 32'(bus.vld_rx), 32'd0);
    chk("glitch_frm", 32'(got_frm), 32'(exp_frm));
    chk("glitch_state", 32'(dut.r_state), 32'(IDLE));

    send(8'h55, 1'b0);
    bus.rxd = 1'b0;
    repeat (640) @(posedge clk);
    #1;
    bus.rxd = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    exp_frm++;
    chk("break_frm", 32'(got_frm), 32'(exp_frm));
    check_q("break_nopush");
    send(8'h81, 1'b1); model_frame(8'h81, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    check_q("after_break");

    spike_i = 4 * 16 + 9;
    send(8'h5A, 1'b1); model_frame(8'h5A, 1'b1);
    spike_i = -1;
    repeat (5) @(posedge clk);
    #1;
    check_q("spike");

    rst_i = 5 * 16 + 5;
    send(8'hFF, 1'b1);
    rst_i = -1;
    repeat (20) @(posedge clk);
    #1;
    check_q("reset_abort");
    send(8'h12, 1'b1); model_frame(8'h12, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    check_q("after_reset");

    for (int n = 0; n < 8; n++) begin
      rb      = 8'($urandom);
      spike_i = int'($urandom_range(16, 143));
      lat_chk = 1'b1;
      send(rb, 1'b1);
      model_frame(rb, 1'b1);
      lat_chk = 1'b0;
      spike_i = -1;
      repeat ($urandom_range(0, 20)) @(posedge clk);
      #1;
    end
    repeat (5) @(posedge clk);
    #1;
    check_q("random");
    chk("final_frm", 32'(got_frm), 32'(exp_frm));
    chk("final_ovf", 32'(got_ovf), 32'(exp_ovf));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
